// File: rtl/ship_life_ctl.sv
// Ship damage / lives / respawn controller with a heart-marker lives overlay
// inserted in-line on the VGA timing stream (one cycle of video latency).
module ship_life_ctl #(
    parameter int N_MISSILES   = 5,
    parameter int MAX_LIVES    = 3,
    parameter int SHIP_Y       = 680,
    parameter int SHIP_W       = 64,
    parameter int SHIP_H       = 64,
    parameter int HIT_FRAMES   = 60,
    parameter int BLINK_FRAMES = 120,
    parameter int HEART_X      = 20,
    parameter int HEART_Y      = 50,
    parameter int HEART_PITCH  = 35,
    parameter int HEART_SIZE   = 31,
    parameter logic [11:0] HEART_RGB = 12'hF00
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [10:0]               ship_x,
    input  logic [11*N_MISSILES-1:0]  en_missile_x,
    input  logic [11*N_MISSILES-1:0]  en_missile_y,
    input  logic                      add_life,
    input  logic                      restart,
    input  logic [10:0]               hcount_in,
    input  logic [10:0]               vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      hblnk_in,
    input  logic                      vblnk_in,
    input  logic [11:0]               rgb_in,
    output logic [10:0]               hcount_out,
    output logic [10:0]               vcount_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      hblnk_out,
    output logic                      vblnk_out,
    output logic [11:0]               rgb_out,
    output logic [3:0]                lives,
    output logic [3:0]                dead_count,
    output logic                      ship_visible,
    output logic                      fire_enable,
    output logic                      hit_pulse,
    output logic                      game_over
);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_HIT       = 2'd1,
        ST_RESPAWN   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [11:0] SHIP_W_12   = 12'(SHIP_W);
    localparam logic [11:0] SHIP_TOP_12 = 12'(SHIP_Y);
    localparam logic [11:0] SHIP_BOT_12 = 12'(SHIP_Y + SHIP_H);
    localparam logic [3:0]  MAX_LIVES_4 = 4'(MAX_LIVES);

    state_t      state_q, state_d;
    logic [3:0]  lives_q, lives_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        vsync_q, hit_q;
    logic [11:0] rgb_q, rgb_d;
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_out_q, hblnk_q, vblnk_q;

    logic [N_MISSILES-1:0] chan_hit;
    logic [MAX_LIVES-1:0]  heart_on;
    logic                  frame_tick;
    logic [3:0]            lives_inc;
    logic [9:0]            cnt_inc;

    // Sums are formed in 12 bits so a ship near the right edge cannot wrap.
    for (genvar gi = 0; gi < N_MISSILES; gi++) begin : g_chan
        logic [10:0] mx, my;
        assign mx = en_missile_x[11*gi +: 11];
        assign my = en_missile_y[11*gi +: 11];
        assign chan_hit[gi] = (my != 11'h7FF)
                           && ({1'b0, mx} >= {1'b0, ship_x})
                           && ({1'b0, mx} <  ({1'b0, ship_x} + SHIP_W_12))
                           && ({1'b0, my} >= SHIP_TOP_12)
                           && ({1'b0, my} <  SHIP_BOT_12);
    end

    for (genvar gi = 0; gi < MAX_LIVES; gi++) begin : g_heart
        localparam int TOP = HEART_Y + gi * HEART_PITCH;
        logic [31:0] h32, v32;
        assign h32 = {21'd0, hcount_in};
        assign v32 = {21'd0, vcount_in};
        assign heart_on[gi] = (h32 >= 32'(HEART_X)) && (h32 < 32'(HEART_X + HEART_SIZE))
                           && (v32 >= 32'(TOP))     && (v32 < 32'(TOP + HEART_SIZE))
                           && (4'(gi) < lives_q);
    end

    always_comb begin
        rgb_d = rgb_in;
        if (hblnk_in || vblnk_in)
            rgb_d = 12'h000;
        else if (|heart_on)
            rgb_d = HEART_RGB;
    end

    assign frame_tick = vsync_in & ~vsync_q;
    assign lives_inc  = (lives_q < MAX_LIVES_4) ? lives_q + 4'd1 : lives_q;
    assign cnt_inc    = cnt_q + 10'd1;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= ST_ALIVE;
            lives_q     <= MAX_LIVES_4;
            cnt_q       <= 10'd0;
            hit_pulse_q <= 1'b0;
            vsync_q     <= 1'b0;
            hit_q       <= 1'b0;
            rgb_q       <= 12'h000;
            hcount_q    <= 11'd0;
            vcount_q    <= 11'd0;
            hsync_q     <= 1'b0;
            vsync_out_q <= 1'b0;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            hit_pulse_q <= hit_pulse_d;
            vsync_q     <= vsync_in;
            hit_q       <= |chan_hit;
            rgb_q       <= rgb_d;
            hcount_q    <= hcount_in;
            vcount_q    <= vcount_in;
            hsync_q     <= hsync_in;
            vsync_out_q <= vsync_in;
            hblnk_q     <= hblnk_in;
            vblnk_q     <= vblnk_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        hit_pulse_d = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                if (hit_q) begin
                    hit_pulse_d = 1'b1;
                    cnt_d       = 10'd0;
                    // A bonus life landing with the hit cancels the loss.
                    if (add_life) begin
                        state_d = ST_HIT;
                    end else if (lives_q == 4'd1) begin
                        lives_d = 4'd0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q - 4'd1;
                        state_d = ST_HIT;
                    end
                end else if (add_life) begin
                    lives_d = lives_inc;
                end
            end
            ST_HIT: begin
                if (add_life) lives_d = lives_inc;
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 10'(HIT_FRAMES)) begin
                        cnt_d   = 10'd0;
                        state_d = ST_RESPAWN;
                    end
                end
            end
            ST_RESPAWN: begin
                if (add_life) lives_d = lives_inc;
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 10'(BLINK_FRAMES)) begin
                        cnt_d   = 10'd0;
                        state_d = ST_ALIVE;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (restart) begin
                    lives_d = MAX_LIVES_4;
                    cnt_d   = 10'd0;
                    state_d = ST_ALIVE;
                end
            end
            default: state_d = ST_ALIVE;
        endcase
    end

    always_comb begin
        ship_visible = 1'b1;
        fire_enable  = 1'b1;
        game_over    = 1'b0;
        case (state_q)
            ST_ALIVE:     ;
            ST_HIT:       begin ship_visible = 1'b0; fire_enable = 1'b0; end
            ST_RESPAWN:   ship_visible = ~cnt_q[3];
            ST_GAME_OVER: begin ship_visible = 1'b0; fire_enable = 1'b0; game_over = 1'b1; end
            default:      ;
        endcase
    end

    assign lives      = lives_q;
    assign dead_count = MAX_LIVES_4 - lives_q;
    assign hit_pulse  = hit_pulse_q;
    assign rgb_out    = rgb_q;
    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_out_q;
    assign hblnk_out  = hblnk_q;
    assign vblnk_out  = vblnk_q;

endmodule

// File: doc/ship_life_ctl.md
# ship_life_ctl

Parametrised ship damage, lives and respawn controller with an in-line lives overlay on the VGA timing stream. It checks up to N_MISSILES enemy missiles against the ship hitbox and runs a hit/respawn state machine with frame-counted invulnerability. It keeps a saturating lives counter with bonus-life support and draws one solid heart marker per remaining life. It sits after the ship and missile drawing stages in the ship pipeline, and feeds ship visibility and fire enable back to the ship position, ship drawing and missile control blocks.

## Interface
Parameters:
- N_MISSILES, 5: number of enemy missile channels (1..16)
- MAX_LIVES, 3: starting and maximum lives (1..15)
- SHIP_Y, 680: top row of the ship hitbox
- SHIP_W, 64: hitbox width in pixels
- SHIP_H, 64: hitbox height in pixels
- HIT_FRAMES, 60: frames spent in HIT (1..1023)
- BLINK_FRAMES, 120: frames of invulnerable blinking in RESPAWN (1..1023)
- HEART_X, 20: left column of the heart markers
- HEART_Y, 50: top row of heart 0
- HEART_PITCH, 35: vertical step between hearts
- HEART_SIZE, 31: edge length of the square heart box
- HEART_RGB, 12'hF00: heart colour

Ports (one clock; reset is synchronous and active-high):
- pclk, input, 1: pixel clock; all logic clocked on its rising edge
- rst, input, 1: synchronous active-high reset
- ship_x, input, 11: left column of the ship
- en_missile_x, input, 11*N_MISSILES: flattened enemy missile X; channel i occupies bits [11*i+10 : 11*i]
- en_missile_y, input, 11*N_MISSILES: flattened enemy missile Y; 11'h7FF marks the channel inactive
- add_life, input, 1: one-cycle bonus-life request
- restart, input, 1: one-cycle new-game request, honoured only in GAME_OVER
- hcount_in, vcount_in, input, 11 each: VGA timing counters
- hsync_in, vsync_in, hblnk_in, vblnk_in, input, 1 each: VGA timing signals
- rgb_in, input, 12: upstream pixel colour
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, output, same widths: timing and pixel, delayed by 1 cycle
- lives, output, 4: remaining lives
- dead_count, output, 4: MAX_LIVES − lives
- ship_visible, output, 1: ship drawing enable
- fire_enable, output, 1: player missile enable
- hit_pulse, output, 1: one-cycle pulse per accepted hit
- game_over, output, 1: high while in GAME_OVER

## Operation
- **Frame tick:** one-cycle pulse on each rising edge of vsync_in, found by comparing with a registered copy of vsync_in.
- **Collision:** channel i hits when all of these hold, compared as unsigned 11-bit values widened to 12 bits so the sums cannot wrap:
  - y_i ≠ 11'h7FF
  - ship_x ≤ x_i < ship_x+SHIP_W
  - SHIP_Y ≤ y_i < SHIP_Y+SHIP_H
- **Hit register:** the OR of all channel hits is registered (hit_r).
- **State machine** (states ALIVE, HIT, RESPAWN, GAME_OVER; frame_cnt is 10 bits):
  - ALIVE:
    - hit_r=1 and lives=1: lives←0, hit_pulse=1, next state GAME_OVER.
    - hit_r=1 and lives>1: lives−1, hit_pulse=1, frame_cnt←0, next state HIT.
    - ship_visible=1, fire_enable=1.
  - HIT:
    - ship_visible=0, fire_enable=0, collisions ignored.
    - frame_cnt increments on each frame tick.
    - The tick that brings frame_cnt to HIT_FRAMES clears frame_cnt and moves to RESPAWN.
  - RESPAWN:
    - ship_visible = ~frame_cnt[3], so the ship blinks with an 8-frame half-period.
    - fire_enable=1, collisions ignored.
    - The tick that brings frame_cnt to BLINK_FRAMES moves to ALIVE.
  - GAME_OVER:
    - ship_visible=0, fire_enable=0, game_over=1, add_life ignored.
    - restart: lives←MAX_LIVES, next state ALIVE.
- **add_life:** in ALIVE, HIT or RESPAWN, lives+1, saturating at MAX_LIVES.
- **add_life and an accepted hit in the same cycle:** lives unchanged, hit_pulse=1, next state HIT. GAME_OVER is not entered.
- **Overlay:** heart k (0 ≤ k < MAX_LIVES) covers
  - columns HEART_X ≤ hcount_in < HEART_X+HEART_SIZE
  - rows HEART_Y+k·HEART_PITCH ≤ vcount_in < HEART_Y+k·HEART_PITCH+HEART_SIZE
- **Overlay colour:** if hblnk_in or vblnk_in is high, rgb_out←12'h000. Otherwise rgb_out←HEART_RGB when the pixel lies inside heart k and k < lives, else rgb_in. The lives value sampled in the same cycle is used.

## Timing
- **Reset values:**
  - State ALIVE, lives=MAX_LIVES, dead_count=0, frame_cnt=0.
  - ship_visible=1, fire_enable=1, hit_pulse=0, game_over=0.
  - All video outputs 0.
- **Hit latency:** missile inside the hitbox at cycle t → hit_r at t+1 → hit_pulse and the lives update at t+2.
- **One hit per entry to ALIVE:** a missile staying inside the hitbox causes exactly one hit, because HIT ignores collisions.
- **Video latency:** exactly 1 cycle for every timing signal and rgb.
- **Reset mid-operation:** overrides every state, including mid-HIT and mid-GAME_OVER.
- **Frame counting:** restart and add_life take effect on the cycle they are sampled. Frame ticks during reset are not counted.

## Test plan
- **Single hit:** defaults; ship_x=100, one missile at (120,700) held for 3 cycles → one hit_pulse at t+2, lives 3→2, dead_count=1. After 60 frames, RESPAWN with ship_visible toggling every 8 frames; ALIVE after 120 more frames.
- **Game over:** three hits separated by full respawns → game_over=1, lives=0, fire_enable=0. Restart pulse → lives=3, ALIVE. A restart pulse while ALIVE has no effect.
- **Edges and inactive channel:** missile at x=ship_x+64 → no hit; at x=ship_x+63 → hit. y=11'h7FF with x inside the hitbox → no hit. ship_x=2000 with x=2040 → hit, no wrap.
- **Bonus life and coincidences:** add_life at lives=3 → stays 3. Hit and add_life in the same cycle at lives=1 → lives=1, state HIT, no game_over.
- **Overlay:** lives=2 → heart 0 at (20..50, 50..80) and heart 1 at (20..50, 85..115) show 12'hF00; heart 2 area passes rgb_in through; blanking forces 0. All outputs lag inputs by exactly 1 cycle.
